// File: rtl/operand_fetch_stage.sv
// Register-read and operand-select stage: decodes one instruction per handshake, reads rs/rt
// from a 32x32 register file with write-through bypass, and registers the ALU operands.
module operand_fetch_stage #(
    parameter int unsigned REG_COUNT  = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic [31:0]           inInstruction,
    input  logic                  wbEn,
    input  logic [4:0]            wbAddr,
    input  logic [DATA_WIDTH-1:0] wbData,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [1:0]            aluOp,
    output logic [31:0]           instruction,
    output logic [DATA_WIDTH-1:0] muxOutA,
    output logic [DATA_WIDTH-1:0] muxOutB,
    output logic [DATA_WIDTH-1:0] storeData,
    output logic [4:0]            destReg,
    output logic                  regWrite,
    output logic                  illegal
);

    localparam logic [5:0] OpRType = 6'h00;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpSlti  = 6'h0A;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];

    logic [5:0]            op_code;
    logic [4:0]            rs, rt, rd;
    logic [15:0]           imm;
    logic [DATA_WIDTH-1:0] rs_val, rt_val, sign_ext, zero_ext;

    logic [1:0]            alu_op_d;
    logic [DATA_WIDTH-1:0] b_d;
    logic [4:0]            dest_d;
    logic                  reg_write_d, illegal_d;

    logic                  valid_q, reg_write_q, illegal_q;
    logic [1:0]            alu_op_q;
    logic [31:0]           instr_q;
    logic [DATA_WIDTH-1:0] a_q, b_q, store_q;
    logic [4:0]            dest_q;
    logic                  accept;

    assign op_code  = inInstruction[31:26];
    assign rs       = inInstruction[25:21];
    assign rt       = inInstruction[20:16];
    assign rd       = inInstruction[15:11];
    assign imm      = inInstruction[15:0];
    assign sign_ext = {{(DATA_WIDTH-16){imm[15]}}, imm};
    assign zero_ext = {{(DATA_WIDTH-16){1'b0}}, imm};

    assign inReady = !valid_q || outReady;
    assign accept  = inValid && inReady;

    // R0 is hardwired; otherwise a same-cycle writeback wins over the stored value.
    always_comb begin
        rs_val = regs_q[rs];
        if (rs == 5'd0) begin
            rs_val = '0;
        end else if (wbEn && (wbAddr == rs)) begin
            rs_val = wbData;
        end
    end

    always_comb begin
        rt_val = regs_q[rt];
        if (rt == 5'd0) begin
            rt_val = '0;
        end else if (wbEn && (wbAddr == rt)) begin
            rt_val = wbData;
        end
    end

    always_comb begin
        alu_op_d    = 2'b00;
        b_d         = '0;
        dest_d      = 5'd0;
        reg_write_d = 1'b0;
        illegal_d   = 1'b0;
        case (op_code)
            OpRType: begin
                alu_op_d    = 2'b10;
                b_d         = rt_val;
                dest_d      = rd;
                reg_write_d = 1'b1;
            end
            OpAddi, OpLw: begin
                b_d         = sign_ext;
                dest_d      = rt;
                reg_write_d = 1'b1;
            end
            OpSlti: begin
                alu_op_d    = 2'b11;
                b_d         = sign_ext;
                dest_d      = rt;
                reg_write_d = 1'b1;
            end
            OpAndi, OpOri: begin
                alu_op_d    = 2'b11;
                b_d         = zero_ext;
                dest_d      = rt;
                reg_write_d = 1'b1;
            end
            OpSw: begin
                b_d = sign_ext;
            end
            OpBeq: begin
                alu_op_d = 2'b01;
                b_d      = rt_val;
            end
            default: begin
                illegal_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            for (int i = 0; i < int'(REG_COUNT); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wbEn && (wbAddr != 5'd0)) begin
            regs_q[wbAddr] <= wbData;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            valid_q     <= 1'b0;
            alu_op_q    <= 2'b00;
            instr_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            store_q     <= '0;
            dest_q      <= 5'd0;
            reg_write_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else if (accept) begin
            valid_q     <= 1'b1;
            alu_op_q    <= alu_op_d;
            instr_q     <= inInstruction;
            a_q         <= rs_val;
            b_q         <= b_d;
            store_q     <= rt_val;
            dest_q      <= dest_d;
            reg_write_q <= reg_write_d;
            illegal_q   <= illegal_d;
        end else if (outReady) begin
            valid_q <= 1'b0;
        end
    end

    assign outValid    = valid_q;
    assign aluOp       = alu_op_q;
    assign instruction = instr_q;
    assign muxOutA     = a_q;
    assign muxOutB     = b_q;
    assign storeData   = store_q;
    assign destReg     = dest_q;
    assign regWrite    = reg_write_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench for operand_fetch_stage: directed scenarios plus a randomized run
// scored against a register-array/one-entry-buffer reference model.
module tb_operand_fetch_stage;

    logic        clk = 1'b0;
    logic        rstN, inValid, inReady, wbEn, outValid, outReady, regWrite, illegal;
    logic [31:0] inInstruction, wbData, instruction, muxOutA, muxOutB, storeData;
    logic [4:0]  wbAddr, destReg;
    logic [1:0]  aluOp;

    int checks = 0;
    int passes = 0;

    logic [31:0] mregs [32];

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] ins;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
        logic [4:0]  dest;
        logic        rw;
        logic        ill;
    } obs_t;

    obs_t obs;
    assign obs = {aluOp, instruction, muxOutA, muxOutB, storeData, destReg, regWrite, illegal};

    always #5 clk = ~clk;

    operand_fetch_stage dut (
        .clk           (clk),
        .rstN          (rstN),
        .inValid       (inValid),
        .inReady       (inReady),
        .inInstruction (inInstruction),
        .wbEn          (wbEn),
        .wbAddr        (wbAddr),
        .wbData        (wbData),
        .outValid      (outValid),
        .outReady      (outReady),
        .aluOp         (aluOp),
        .instruction   (instruction),
        .muxOutA       (muxOutA),
        .muxOutB       (muxOutB),
        .storeData     (storeData),
        .destReg       (destReg),
        .regWrite      (regWrite),
        .illegal       (illegal)
    );

    function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t,
                                          input logic [4:0] d);
        return {6'h00, s, t, d, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] im);
        return {op, s, t, im};
    endfunction

    // Expected stage output for an instruction read against the current model registers.
    function automatic obs_t model(input logic [31:0] ins);
        obs_t        m;
        logic [31:0] rsv, rtv, sx, zx;
        rsv   = mregs[ins[25:21]];
        rtv   = mregs[ins[20:16]];
        sx    = 32'(signed'(ins[15:0]));
        zx    = 32'(ins[15:0]);
        m     = '0;
        m.ins = ins;
        m.a   = rsv;
        m.sd  = rtv;
        case (ins[31:26])
            6'h00: begin m.op = 2'd2; m.b = rtv; m.dest = ins[15:11]; m.rw = 1'b1; end
            6'h08: begin m.op = 2'd0; m.b = sx; m.dest = ins[20:16]; m.rw = 1'b1; end
            6'h0A: begin m.op = 2'd3; m.b = sx; m.dest = ins[20:16]; m.rw = 1'b1; end
            6'h0C, 6'h0D: begin m.op = 2'd3; m.b = zx; m.dest = ins[20:16]; m.rw = 1'b1; end
            6'h23: begin m.op = 2'd0; m.b = sx; m.dest = ins[20:16]; m.rw = 1'b1; end
            6'h2B: begin m.op = 2'd0; m.b = sx; end
            6'h04: begin m.op = 2'd1; m.b = rtv; end
            default: m.ill = 1'b1;
        endcase
        return m;
    endfunction

    // One rising edge; the model register file follows the same edge, then sample #1 later.
    task automatic tick();
        @(posedge clk);
        if (!rstN) begin
            foreach (mregs[i]) mregs[i] = '0;
        end else if (wbEn && wbAddr != 5'd0) begin
            mregs[wbAddr] = wbData;
        end
        #1;
    endtask

    task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
        wbEn = 1'b1; wbAddr = addr; wbData = data;
        tick();
        wbEn = 1'b0;
    endtask

    task automatic issue(input logic [31:0] ins, output obs_t e);
        inValid = 1'b1; inInstruction = ins; outReady = 1'b1;
        tick();
        e = model(ins);
        inValid = 1'b0; wbEn = 1'b0;
    endtask

    task automatic test_reset();
        obs_t e;
        rstN = 1'b0; inValid = 1'b1; inInstruction = rtype(5'd2, 5'd3, 5'd1);
        wbEn = 1'b1; wbAddr = 5'd2; wbData = 32'h5; outReady = 1'b0;
        tick();
        tick();
        checks++;
        if (outValid !== 1'b0) $display("FAIL reset_valid got %0b want 0", outValid);
        else passes++;
        checks++;
        if (obs !== '0) $display("FAIL reset_outputs got %h want 0", obs);
        else passes++;
        rstN = 1'b1; inValid = 1'b0; wbEn = 1'b0;
        tick();
        issue(rtype(5'd2, 5'd3, 5'd1), e);
        checks++;
        if (outValid !== 1'b1 || muxOutA !== 32'h0 || muxOutB !== 32'h0)
            $display("FAIL reset_after_add got v=%0b a=%h b=%h want v=1 a=0 b=0",
                     outValid, muxOutA, muxOutB);
        else passes++;
    endtask

    task automatic test_rtype();
        obs_t e;
        do_write(5'd5, 32'h0000_0007);
        do_write(5'd6, 32'hFFFF_FFFF);
        issue(32'h00A6_1820, e);
        checks++;
        if (outValid !== 1'b1 || muxOutA !== 32'h7 || muxOutB !== 32'hFFFF_FFFF ||
            aluOp !== 2'b10 || destReg !== 5'd3 || regWrite !== 1'b1)
            $display("FAIL rtype_add got v=%0b a=%h b=%h op=%0d dst=%0d rw=%0b want 1 7 ffffffff 2 3 1",
                     outValid, muxOutA, muxOutB, aluOp, destReg, regWrite);
        else passes++;
        checks++;
        if (obs !== e) $display("FAIL rtype_model got %h want %h", obs, e);
        else passes++;
        tick();
        checks++;
        if (outValid !== 1'b0) $display("FAIL rtype_drain got %0b want 0", outValid);
        else passes++;
    endtask

    task automatic test_immediate();
        obs_t e;
        issue(itype(6'h08, 5'd5, 5'd2, 16'hFFFC), e);
        checks++;
        if (muxOutB !== 32'hFFFF_FFFC || aluOp !== 2'b00 || destReg !== 5'd2)
            $display("FAIL imm_addi got b=%h op=%0d dst=%0d want fffffffc 0 2",
                     muxOutB, aluOp, destReg);
        else passes++;
        issue(itype(6'h0D, 5'd5, 5'd2, 16'hFFFC), e);
        checks++;
        if (muxOutB !== 32'h0000_FFFC || aluOp !== 2'b11)
            $display("FAIL imm_ori got b=%h op=%0d want 0000fffc 3", muxOutB, aluOp);
        else passes++;
        checks++;
        if (obs !== e) $display("FAIL imm_model got %h want %h", obs, e);
        else passes++;
    endtask

    task automatic test_backpressure();
        obs_t e1, e2;
        logic [31:0] ins2;
        ins2 = rtype(5'd5, 5'd6, 5'd7);
        issue(32'h00A6_1820, e1);
        outReady = 1'b0; inValid = 1'b1; inInstruction = ins2;
        wbEn = 1'b1; wbAddr = 5'd5; wbData = 32'h0000_AAAA;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (inReady !== 1'b0) $display("FAIL bp_inready got %0b want 0", inReady);
            else passes++;
            tick();
            wbEn = 1'b0;
            checks++;
            if (outValid !== 1'b1 || obs !== e1)
                $display("FAIL bp_hold got v=%0b %h want v=1 %h", outValid, obs, e1);
            else passes++;
        end
        outReady = 1'b1;
        #1;
        checks++;
        if (inReady !== 1'b1) $display("FAIL bp_release_ready got %0b want 1", inReady);
        else passes++;
        tick();
        e2 = model(ins2);
        inValid = 1'b0;
        checks++;
        if (outValid !== 1'b1 || obs !== e2 || muxOutA !== 32'h0000_AAAA)
            $display("FAIL bp_swap got v=%0b %h want v=1 %h", outValid, obs, e2);
        else passes++;
    endtask

    task automatic test_bypass_r0();
        obs_t e;
        wbEn = 1'b1; wbAddr = 5'd9; wbData = 32'h0000_1234;
        issue(itype(6'h04, 5'd9, 5'd0, 16'h0003), e);
        checks++;
        if (muxOutA !== 32'h1234 || muxOutB !== 32'h0 || aluOp !== 2'b01 ||
            regWrite !== 1'b0 || destReg !== 5'd0)
            $display("FAIL bypass_beq got a=%h b=%h op=%0d rw=%0b dst=%0d want 1234 0 1 0 0",
                     muxOutA, muxOutB, aluOp, regWrite, destReg);
        else passes++;
        do_write(5'd0, 32'h0000_DEAD);
        issue(rtype(5'd0, 5'd0, 5'd4), e);
        checks++;
        if (muxOutA !== 32'h0 || muxOutB !== 32'h0)
            $display("FAIL r0_read got a=%h b=%h want 0 0", muxOutA, muxOutB);
        else passes++;
        // A same-cycle write to R0 must not be bypassed either.
        wbEn = 1'b1; wbAddr = 5'd0; wbData = 32'h0000_DEAD;
        issue(rtype(5'd0, 5'd9, 5'd4), e);
        checks++;
        if (muxOutA !== 32'h0 || muxOutB !== 32'h1234)
            $display("FAIL r0_bypass got a=%h b=%h want 0 1234", muxOutA, muxOutB);
        else passes++;
    endtask

    task automatic test_illegal();
        obs_t e;
        issue({6'h3F, 26'h2A5_1234}, e);
        checks++;
        if (outValid !== 1'b1 || illegal !== 1'b1 || regWrite !== 1'b0 || muxOutB !== 32'h0)
            $display("FAIL illegal_op got v=%0b ill=%0b rw=%0b b=%h want 1 1 0 0",
                     outValid, illegal, regWrite, muxOutB);
        else passes++;
        checks++;
        if (obs !== e) $display("FAIL illegal_model got %h want %h", obs, e);
        else passes++;
        tick();
        checks++;
        if (outValid !== 1'b0) $display("FAIL illegal_drain got %0b want 0", outValid);
        else passes++;
    endtask

    task automatic test_reset_mid();
        obs_t e;
        issue(rtype(5'd5, 5'd9, 5'd1), e);
        outReady = 1'b0; rstN = 1'b0; inValid = 1'b1;
        tick();
        rstN = 1'b1; inValid = 1'b0;
        checks++;
        if (outValid !== 1'b0 || obs !== '0)
            $display("FAIL reset_mid got v=%0b %h want v=0 0", outValid, obs);
        else passes++;
        issue(rtype(5'd5, 5'd9, 5'd1), e);
        checks++;
        if (muxOutA !== 32'h0 || muxOutB !== 32'h0)
            $display("FAIL reset_mid_regs got a=%h b=%h want 0 0", muxOutA, muxOutB);
        else passes++;
    endtask

    task automatic test_random();
        logic [5:0] ops [9];
        obs_t       e;
        logic       exp_valid, exp_ready, acc;
        ops = '{6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h3F};
        inValid = 1'b0; outReady = 1'b1; wbEn = 1'b0;
        tick();
        exp_valid = 1'b0;
        e = '0;
        for (int n = 0; n < 400; n++) begin
            inValid       = ($urandom_range(0, 3) != 0);
            outReady      = ($urandom_range(0, 2) != 0);
            inInstruction = {ops[$urandom_range(0, 8)], 2'b00, 3'($urandom), 2'b00,
                             3'($urandom), 16'($urandom)};
            wbEn          = 1'($urandom);
            wbAddr        = 5'($urandom_range(0, 7));
            wbData        = $urandom;
            #1;
            exp_ready = !exp_valid || outReady;
            checks++;
            if (inReady !== exp_ready)
                $display("FAIL rand_inready cyc %0d got %0b want %0b", n, inReady, exp_ready);
            else passes++;
            acc = inValid && exp_ready;
            tick();
            if (acc) begin
                e = model(inInstruction);
                exp_valid = 1'b1;
            end else if (outReady) begin
                exp_valid = 1'b0;
            end
            checks++;
            if (outValid !== exp_valid || (exp_valid && obs !== e))
                $display("FAIL rand_out cyc %0d got v=%0b %h want v=%0b %h",
                         n, outValid, obs, exp_valid, e);
            else passes++;
        end
        inValid = 1'b0; wbEn = 1'b0;
    endtask

    initial begin
        rstN = 1'b0; inValid = 1'b0; inInstruction = '0; wbEn = 1'b0; wbAddr = '0;
        wbData = '0; outReady = 1'b0;
        foreach (mregs[i]) mregs[i] = '0;
        test_reset();
        test_rtype();
        test_immediate();
        test_backpressure();
        test_bypass_r0();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/operand_fetch_stage.md
# operand_fetch_stage

Register-read and operand-select stage feeding the ALU block (ALU control plus ALU datapath). Accepts one 32-bit MIPS-style instruction per handshake, reads `rs`/`rt` from an internal 32x32 register file, and forms the immediate. It registers `aluOp`, `instruction`, `muxOutA` and `muxOutB` for the downstream stage, with valid/ready flow control. Register writes arrive on a separate writeback port from later pipeline stages.

## Interface
- `REG_COUNT`, 32, number of architectural registers; `rs`/`rt`/`rd` are 5 bits.
- `DATA_WIDTH`, 32, register and operand width.
- `clk`  in  1  rising-edge clock, the only clock.
- `rstN`  in  1  reset, synchronous, active-low.
- `inValid`  in  1  upstream presents `inInstruction`.
- `inReady`  out  1  stage can accept this cycle.
- `inInstruction`  in  32  instruction word.
- `wbEn`  in  1  register write request.
- `wbAddr`  in  5  register written.
- `wbData`  in  32  data written.
- `outValid`  out  1  downstream outputs valid.
- `outReady`  in  1  downstream accepts.
- `aluOp`  out  2  ALU op class.
- `instruction`  out  32  registered copy of the accepted instruction.
- `muxOutA`  out  32  operand A.
- `muxOutB`  out  32  operand B.
- `storeData`  out  32  `rt` value, used by stores.
- `destReg`  out  5  writeback target.
- `regWrite`  out  1  instruction writes `destReg`.
- `illegal`  out  1  opcode not supported.

## Operation
- **Field decode:** `opCode` = [31:26], `rs` = [25:21], `rt` = [20:16], `rd` = [15:11], `imm` = [15:0].
- **Opcode map:**
  - R-type 0x00: A = R[rs], B = R[rt], `aluOp` = 10, `destReg` = `rd`, `regWrite` = 1.
  - addi 0x08 and slti 0x0A: B = sign-extended `imm`, `aluOp` = 00 for addi, 11 for slti, `destReg` = `rt`, `regWrite` = 1.
  - andi 0x0C and ori 0x0D: B = zero-extended `imm`, `aluOp` = 11, `destReg` = `rt`, `regWrite` = 1.
  - lw 0x23: B = sign-extended `imm`, `aluOp` = 00, `destReg` = `rt`, `regWrite` = 1.
  - sw 0x2B: B = sign-extended `imm`, `aluOp` = 00, `regWrite` = 0.
  - beq 0x04: B = R[rt], `aluOp` = 01, `regWrite` = 0.
  - Any other opcode: `illegal` = 1, `aluOp` = 00, B = 0, `regWrite` = 0.
- **Operand A:** A = R[rs] for every opcode.
- **Store data:** `storeData` = R[rt] always.
- **Destination register:** `destReg` = 0 whenever `regWrite` = 0.
- **Register file:** R[0] reads 0 always; writes to address 0 are discarded.
- **Write-through bypass:** a writeback in the same cycle as an accept of an instruction reading that register supplies `wbData`, not the stale value.
- **Output buffer:** one-entry output register.
  - `inReady` = !`outValid` || `outReady`, combinational.
  - Accept happens when `inValid` && `inReady` at a rising edge.
  - On accept, `outValid` becomes 1 next cycle.
  - If `outReady` is 1 with no accept, `outValid` clears.
- **Output stability:** while `outValid` && !`outReady`, all outputs hold stable.

## Timing
- **Latency:** 1 cycle from accept to `outValid`. Throughput is 1 instruction/cycle when `outReady` is held high.
- **Reset (`rstN` = 0 at an edge):**
  - `outValid`, `aluOp`, `instruction`, `muxOutA`, `muxOutB`, `storeData`, `destReg`, `regWrite`, `illegal` become 0.
  - All registers clear to 0.
  - An accept in the same cycle is dropped.
  - A writeback in the same cycle is dropped.
- **Reset mid-transfer:** a held, unconsumed output is discarded. No partial state survives.
- **Writeback visibility:**
  - A write at edge N is visible to reads at accepts from edge N onward.
  - An entry already held in the output register is not updated by later writebacks. Hazard control is upstream's responsibility.
- **Simultaneous accept and drain:** when `outValid` = 1, `outReady` = 1 and `inValid` = 1, the new entry replaces the old at the same edge and `outValid` stays 1.
- **Arithmetic:** sign extension replicates `imm`[15] into [31:16]; zero extension fills [31:16] with 0. No other arithmetic is performed.

## Test plan
- **Reset:** hold `rstN` = 0 for 2 cycles with `inValid` = 1 → `outValid` = 0 and all outputs 0. After release, `add $1,$2,$3` gives `muxOutA` = `muxOutB` = 0.
- **R-type read:** write R5 = 0x00000007 and R6 = 0xFFFFFFFF, then issue `add $3,$5,$6` (0x00A61820) → `muxOutA` = 0x7, `muxOutB` = 0xFFFFFFFF, `aluOp` = 10, `destReg` = 3, `regWrite` = 1, one cycle after accept.
- **Immediate extension:** `addi $2,$5,0xFFFC` → `muxOutB` = 0xFFFFFFFC, `aluOp` = 00, `destReg` = 2. `ori $2,$5,0xFFFC` → `muxOutB` = 0x0000FFFC, `aluOp` = 11.
- **Backpressure:** `outReady` = 0 with `outValid` = 1 and `inValid` = 1 for 3 cycles → `inReady` = 0 and outputs unchanged. Raise `outReady` → the held entry drains and the pending instruction is accepted at the same edge.
- **Bypass and R0:** `wbEn` = 1, `wbAddr` = 9, `wbData` = 0x1234 in the same cycle as accepting `beq $9,$0,x` → `muxOutA` = 0x1234, `muxOutB` = 0, `aluOp` = 01, `regWrite` = 0. A write of 0xDEAD to R0, then a read of R0 → 0.
- **Illegal opcode:** opcode 0x3F → `illegal` = 1, `regWrite` = 0, `muxOutB` = 0, and the handshake completes normally.
